// File: rtl/lbm_counter_init_pkg.sv
// Shared LBM lattice constants for the initialization counter slice.
package lbm_counter_init_pkg;

  localparam int unsigned LBM_GRID_SIDE = 16;
  localparam int unsigned LBM_GRID_DIM  = LBM_GRID_SIDE * LBM_GRID_SIDE;

endpackage

// File: rtl/lbm_counter_init_if.sv
// Enable/address bundle between the init sequencer and the lattice address counter.
interface lbm_counter_init_if
  import lbm_counter_init_pkg::*;
#(
  parameter int unsigned WIDTH = $clog2(LBM_GRID_DIM)
);

  logic             enable;
  logic [WIDTH-1:0] data_out;

  modport master (output enable, input  data_out);
  modport slave  (input  enable, output data_out);

endinterface

// File: rtl/lbm_counter_init.sv
// Enable-gated lattice address counter sweeping 0..GRID_DIM-1, wrapping by explicit compare.
module lbm_counter_init
  import lbm_counter_init_pkg::*;
#(
  parameter int unsigned GRID_DIM      = LBM_GRID_DIM,
  parameter int unsigned ADDRESS_WIDTH = $clog2(GRID_DIM)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Enable,
  output logic [ADDRESS_WIDTH-1:0] Data_out
);

  // Terminal compare rather than binary overflow, so non-power-of-two grids wrap correctly.
  localparam logic [ADDRESS_WIDTH-1:0] LAST = ADDRESS_WIDTH'(GRID_DIM - 1);

  logic [ADDRESS_WIDTH-1:0] count;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      count <= '0;
    end else if (Enable) begin
      if (count == LAST) count <= '0;
      else               count <= count + ADDRESS_WIDTH'(1);
    end
  end

  assign Data_out = count;

endmodule

// File: tb/tb_lbm_counter_init.sv
// Scoreboard bench: a 256-cell counter and a 10-cell counter driven side by side.
module tb_lbm_counter_init;

  logic clk;
  logic rst_a;
  logic rst_b;

  lbm_counter_init_if #(.WIDTH(8)) bus_a ();
  lbm_counter_init_if #(.WIDTH(4)) bus_b ();

  lbm_counter_init #(.GRID_DIM(256)) dut_a (
    .Clk      (clk),
    .Reset    (rst_a),
    .Enable   (bus_a.enable),
    .Data_out (bus_a.data_out)
  );

  lbm_counter_init #(.GRID_DIM(10), .ADDRESS_WIDTH(4)) dut_b (
    .Clk      (clk),
    .Reset    (rst_b),
    .Enable   (bus_b.enable),
    .Data_out (bus_b.data_out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  logic [7:0] q_a[$];
  logic [3:0] q_b[$];
  logic [7:0] mdl_a;
  logic [3:0] mdl_b;
  int         checks   = 0;
  int         failures = 0;

  // Monitor: the DUT presents a new address every edge; compare once it has settled.
  always @(posedge clk) begin
    logic [7:0] ea;
    logic [3:0] eb;
    #1;
    if (q_a.size() > 0) begin
      ea = q_a.pop_front();
      checks++;
      if (bus_a.data_out !== ea) begin
        failures++;
        $display("FAIL dim256 t=%0t got=%0d exp=%0d", $time, bus_a.data_out, ea);
      end
    end
    if (q_b.size() > 0) begin
      eb = q_b.pop_front();
      checks++;
      if (bus_b.data_out !== eb) begin
        failures++;
        $display("FAIL dim10 t=%0t got=%0d exp=%0d", $time, bus_b.data_out, eb);
      end
    end
  end

  // Drive one edge on both counters and queue the value each should show after it.
  task automatic step(input logic ra, input logic ea, input logic rb, input logic eb);
    @(negedge clk);
    rst_a = ra; bus_a.enable = ea;
    rst_b = rb; bus_b.enable = eb;
    if (!ra)     mdl_a = 8'd0;
    else if (ea) mdl_a = (mdl_a == 8'd255) ? 8'd0 : mdl_a + 8'd1;
    if (!rb)     mdl_b = 4'd0;
    else if (eb) mdl_b = (mdl_b == 4'd9) ? 4'd0 : mdl_b + 4'd1;
    q_a.push_back(mdl_a);
    q_b.push_back(mdl_b);
  endtask

  task automatic run_a(input int unsigned n, input logic ea);
    for (int unsigned i = 0; i < n; i++) step(1'b1, ea, 1'b1, 1'b0);
  endtask

  task automatic expect_a(input string name, input logic [7:0] v);
    checks++;
    if (mdl_a !== v) begin
      failures++;
      $display("FAIL plan_%s model=%0d exp=%0d", name, mdl_a, v);
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.enable = 1'b0; bus_b.enable = 1'b0;
    mdl_a = '0; mdl_b = '0;

    // Reset with enable high on both: reset wins.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);

    // Full sweep 1..255 then 0.
    run_a(255, 1'b1);
    expect_a("sweep_top", 8'd255);
    run_a(1, 1'b1);
    expect_a("sweep_wrap", 8'd0);

    // Hold at 10 for 5 edges, then resume to 11.
    run_a(10, 1'b1);
    run_a(5, 1'b0);
    expect_a("hold", 8'd10);
    run_a(1, 1'b1);
    expect_a("resume", 8'd11);

    // Mid-count reset at 100 with enable high.
    run_a(89, 1'b1);
    expect_a("at100", 8'd100);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    run_a(1, 1'b1);
    expect_a("after_rst", 8'd1);

    // Drop enable at 255, then re-enable to wrap.
    run_a(254, 1'b1);
    run_a(3, 1'b0);
    expect_a("wrap_hold", 8'd255);
    run_a(1, 1'b1);
    expect_a("wrap_resume", 8'd0);

    // Ten-cell grid: two and a half passes, hold at 9, resume to 0, then reset.
    for (int unsigned i = 0; i < 25; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    for (int unsigned i = 0; i < 4; i++)  step(1'b1, 1'b0, 1'b1, 1'b1);
    for (int unsigned i = 0; i < 3; i++)  step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    for (int unsigned i = 0; i < 3; i++)  step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);

    // Drain the scoreboard within a bounded number of edges.
    for (int unsigned i = 0; i < 4 && (q_a.size() > 0 || q_b.size() > 0); i++) @(posedge clk);
    @(posedge clk);
    #2;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending_a=%0d pending_b=%0d exp=0", q_a.size(), q_b.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
